// File: rtl/core_wb_bridge.sv
// Core-to-Wishbone bridge: one outstanding transaction, optional pipelined
// response path, and a bus-cycle timeout that returns an error completion.
module core_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RESP_STAGES    = 1,
  parameter int PIPELINED      = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    core_req_i,
  input  logic [DATA_WIDTH/8-1:0] core_we_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  output logic                    core_stall_o,
  output logic                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    core_err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_stall_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CntW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TmoLast   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic                    we_q;
  logic [CntW-1:0]         cnt_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   hold_q;

  logic                    in_bus;
  logic                    ack_cap;
  logic                    tmo_hit;
  logic                    resp_ack;
  logic [DATA_WIDTH-1:0]   resp_data;

  assign in_bus = (state_q == StReq) || (state_q == StWait);

  // In pipelined mode an ack during REQ only counts once the slave has taken stb.
  assign ack_cap = wb_ack_i && ((state_q == StWait) ||
                   ((state_q == StReq) && ((PIPELINED == 0) || !wb_stall_i)));

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && in_bus && !ack_cap &&
                   (cnt_q == CntW'(TmoLast));

  generate
    if (RESP_STAGES == 0) begin : g_resp_comb
      assign resp_ack  = ack_cap;
      assign resp_data = wb_data_i;
    end else begin : g_resp_pipe
      logic [RESP_STAGES-1:0] ack_pipe_q;
      logic [DATA_WIDTH-1:0]  data_pipe_q [RESP_STAGES];

      // Delay line for ack/data; data only moves with its ack so the tail holds.
      always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
          ack_pipe_q <= '0;
          for (int k = 0; k < RESP_STAGES; k++) data_pipe_q[k] <= '0;
        end else begin
          ack_pipe_q[0] <= ack_cap;
          if (ack_cap) data_pipe_q[0] <= wb_data_i;
          for (int k = 1; k < RESP_STAGES; k++) begin
            ack_pipe_q[k] <= ack_pipe_q[k-1];
            if (ack_pipe_q[k-1]) data_pipe_q[k] <= data_pipe_q[k-1];
          end
        end
      end

      assign resp_ack  = ack_pipe_q[RESP_STAGES-1];
      assign resp_data = data_pipe_q[RESP_STAGES-1];
    end
  endgenerate

  // Control FSM plus request latches, timeout counter and read-data hold.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      err_q <= 1'b0;
      if (core_rvalid_o) hold_q <= core_rdata_o;
      if (in_bus) cnt_q <= cnt_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          if (core_req_i) begin
            addr_q  <= core_addr_i;
            wdata_q <= core_wdata_i;
            sel_q   <= (|core_we_i) ? core_we_i : {SEL_WIDTH{1'b1}};
            we_q    <= |core_we_i;
            cnt_q   <= '0;
            state_q <= StReq;
          end
        end
        StReq, StWait: begin
          if (ack_cap) begin
            state_q <= (RESP_STAGES == 0) ? StIdle : StDrain;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else if ((state_q == StReq) && (PIPELINED != 0) && !wb_stall_i) begin
            state_q <= StWait;
          end
        end
        StDrain: begin
          if (resp_ack) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb_cyc_o  = in_bus;
  assign wb_stb_o  = (state_q == StReq);
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_addr_o = addr_q;
  assign wb_data_o = wdata_q;

  assign core_err_o    = err_q;
  assign core_rvalid_o = resp_ack || err_q;
  assign core_rdata_o  = err_q ? '0 : (resp_ack ? resp_data : hold_q);
  // Reset gating keeps stall low while rst_n is held, even with a request pending.
  assign core_stall_o  = rst_n && !core_rvalid_o &&
                         ((state_q != StIdle) || core_req_i);

endmodule

// File: tb/tb_core_wb_bridge.sv
module tb_core_wb_bridge;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  core_we;
  logic [31:0] core_addr, core_wdata, wb_data_in;
  logic        wb_stall;

  // Default instance (pipelined, one response stage, long timeout)
  logic        req_a, ack_a, stall_a, rvalid_a, err_a, cyc_a, stb_a, we_a;
  logic [3:0]  sel_a;
  logic [31:0] rdata_a, addr_a, data_a;
  // Short-timeout instance
  logic        req_t, ack_t, stall_t, rvalid_t, err_t, cyc_t, stb_t, we_t;
  logic [3:0]  sel_t;
  logic [31:0] rdata_t, addr_t, data_t;
  // Classic, zero-stage instance
  logic        req_c, ack_c, stall_c, rvalid_c, err_c, cyc_c, stb_c, we_c;
  logic [3:0]  sel_c;
  logic [31:0] rdata_c, addr_c, data_c;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  core_wb_bridge dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .core_req_i(req_a), .core_we_i(core_we),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_stall_o(stall_a),
    .core_rvalid_o(rvalid_a), .core_rdata_o(rdata_a), .core_err_o(err_a),
    .wb_cyc_o(cyc_a), .wb_stb_o(stb_a), .wb_we_o(we_a), .wb_sel_o(sel_a),
    .wb_addr_o(addr_a), .wb_data_o(data_a), .wb_data_i(wb_data_in),
    .wb_ack_i(ack_a), .wb_stall_i(wb_stall)
  );

  core_wb_bridge #(.TIMEOUT_CYCLES(4)) dut_tmo (
    .sys_clk(sys_clk), .rst_n(rst_n), .core_req_i(req_t), .core_we_i(core_we),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_stall_o(stall_t),
    .core_rvalid_o(rvalid_t), .core_rdata_o(rdata_t), .core_err_o(err_t),
    .wb_cyc_o(cyc_t), .wb_stb_o(stb_t), .wb_we_o(we_t), .wb_sel_o(sel_t),
    .wb_addr_o(addr_t), .wb_data_o(data_t), .wb_data_i(wb_data_in),
    .wb_ack_i(ack_t), .wb_stall_i(wb_stall)
  );

  core_wb_bridge #(.PIPELINED(0), .RESP_STAGES(0)) dut_cl (
    .sys_clk(sys_clk), .rst_n(rst_n), .core_req_i(req_c), .core_we_i(core_we),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_stall_o(stall_c),
    .core_rvalid_o(rvalid_c), .core_rdata_o(rdata_c), .core_err_o(err_c),
    .wb_cyc_o(cyc_c), .wb_stb_o(stb_c), .wb_we_o(we_c), .wb_sel_o(sel_c),
    .wb_addr_o(addr_c), .wb_data_o(data_c), .wb_data_i(wb_data_in),
    .wb_ack_i(ack_c), .wb_stall_i(1'b0)
  );

  // Inputs are changed 2 time units after each rising edge, outputs read 1 later.
  task automatic next_cycle();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_a = 1'b1; ack_a = 0; req_t = 0; ack_t = 0; req_c = 0; ack_c = 0;
    core_we = '0; core_addr = '0; core_wdata = '0; wb_data_in = '0; wb_stall = 0;
    #3;
    checks++; if ({cyc_a, stb_a, stall_a, rvalid_a, err_a, we_a} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
                         {cyc_a, stb_a, stall_a, rvalid_a, err_a, we_a}); end
    checks++; if ({rdata_a, addr_a, data_a, sel_a} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", rdata_a, addr_a,
                         data_a, sel_a); end
    req_a = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_pipe_read();
    next_cycle(); req_a = 1; core_addr = 32'h100; core_we = 4'h0; #1;
    checks++; if (stall_a !== 1'b1 || stb_a !== 1'b0) begin errors++;
      $display("FAIL read_t0 got stall=%b stb=%b want 1 0", stall_a, stb_a); end
    next_cycle(); req_a = 0; #1;
    checks++; if ({cyc_a, stb_a, we_a, sel_a} !== 7'b1101111 || addr_a !== 32'h100) begin
      errors++; $display("FAIL read_t1 got cyc=%b stb=%b we=%b sel=%h addr=%h want 1 1 0 f 100",
                         cyc_a, stb_a, we_a, sel_a, addr_a); end
    next_cycle(); ack_a = 1; wb_data_in = 32'hDEADBEEF; #1;
    checks++; if ({cyc_a, stb_a, rvalid_a} !== 3'b100) begin errors++;
      $display("FAIL read_t2 got cyc/stb/rvalid=%b want 100", {cyc_a, stb_a, rvalid_a}); end
    next_cycle(); ack_a = 0; #1;
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'hDEADBEEF || stall_a !== 1'b0 ||
                  err_a !== 1'b0) begin errors++;
      $display("FAIL read_t3 got rvalid=%b rdata=%h stall=%b err=%b want 1 deadbeef 0 0",
               rvalid_a, rdata_a, stall_a, err_a); end
    next_cycle(); #1;
    checks++; if (rvalid_a !== 1'b0 || rdata_a !== 32'hDEADBEEF || cyc_a !== 1'b0) begin
      errors++; $display("FAIL read_hold got rvalid=%b rdata=%h cyc=%b want 0 deadbeef 0",
                         rvalid_a, rdata_a, cyc_a); end
  endtask

  task automatic test_byte_write();
    next_cycle(); req_a = 1; core_addr = 32'h204; core_we = 4'b0010;
    core_wdata = 32'h0000AB00; #1;
    next_cycle(); req_a = 0; core_we = 4'h0; core_wdata = 32'hFFFFFFFF; #1;
    checks++; if (we_a !== 1'b1 || sel_a !== 4'b0010 || data_a !== 32'h0000AB00 ||
                  stb_a !== 1'b1) begin errors++;
      $display("FAIL write_bus got we=%b sel=%b data=%h stb=%b want 1 0010 0000ab00 1",
               we_a, sel_a, data_a, stb_a); end
    next_cycle(); ack_a = 1; wb_data_in = 32'h12345678; #1;
    next_cycle(); ack_a = 0; #1;
    checks++; if (rvalid_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'h12345678) begin
      errors++; $display("FAIL write_done got rvalid=%b err=%b rdata=%h want 1 0 12345678",
                         rvalid_a, err_a, rdata_a); end
    next_cycle(); #1;
    checks++; if (rvalid_a !== 1'b0) begin errors++;
      $display("FAIL write_single got rvalid=%b want 0", rvalid_a); end
  endtask

  task automatic test_stall();
    int stb_cnt = 0;
    int addr_bad = 0;
    next_cycle(); req_a = 1; core_addr = 32'h300; #1;
    for (int i = 0; i < 5; i++) begin
      next_cycle(); req_a = 0; core_addr = 32'h0;
      wb_stall = (i < 3); ack_a = (i == 4); wb_data_in = 32'hCAFE0001; #1;
      if (stb_a) stb_cnt++;
      if (stb_a && addr_a !== 32'h300) addr_bad++;
    end
    checks++; if (stb_cnt !== 4 || addr_bad !== 0) begin errors++;
      $display("FAIL stall_stb got stb_cycles=%0d addr_bad=%0d want 4 0", stb_cnt, addr_bad); end
    next_cycle(); ack_a = 0; wb_stall = 0; #1;
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'hCAFE0001) begin errors++;
      $display("FAIL stall_done got rvalid=%b rdata=%h want 1 cafe0001", rvalid_a, rdata_a); end
  endtask

  task automatic test_ack_in_req();
    next_cycle(); req_a = 1; core_addr = 32'h110; #1;
    next_cycle(); req_a = 0; ack_a = 1; wb_data_in = 32'h00000055; #1;
    next_cycle(); ack_a = 0; #1;
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'h55) begin errors++;
      $display("FAIL ack_req got rvalid=%b rdata=%h want 1 55", rvalid_a, rdata_a); end
    // Spurious ack while idle must not complete anything
    next_cycle(); ack_a = 1; #1;
    next_cycle(); ack_a = 0; #1;
    checks++; if (rvalid_a !== 1'b0 || stall_a !== 1'b0 || cyc_a !== 1'b0) begin errors++;
      $display("FAIL idle_ack got rvalid=%b stall=%b cyc=%b want 0 0 0",
               rvalid_a, stall_a, cyc_a); end
  endtask

  task automatic test_timeout();
    // Ack on the final allowed cycle beats the timeout
    next_cycle(); req_t = 1; core_addr = 32'h700; #1;
    next_cycle(); req_t = 0; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    next_cycle(); ack_t = 1; wb_data_in = 32'h77; #1;
    next_cycle(); ack_t = 0; #1;
    checks++; if (rvalid_t !== 1'b1 || err_t !== 1'b0 || rdata_t !== 32'h77) begin errors++;
      $display("FAIL tmo_tie got rvalid=%b err=%b rdata=%h want 1 0 77",
               rvalid_t, err_t, rdata_t); end
    // No ack at all
    next_cycle(); req_t = 1; core_addr = 32'h704; #1;
    next_cycle(); req_t = 0; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    next_cycle(); #1;
    checks++; if (cyc_t !== 1'b1 || rvalid_t !== 1'b0) begin errors++;
      $display("FAIL tmo_last got cyc=%b rvalid=%b want 1 0", cyc_t, rvalid_t); end
    next_cycle(); #1;
    checks++; if (cyc_t !== 1'b0 || err_t !== 1'b1 || rvalid_t !== 1'b1 ||
                  rdata_t !== 32'h0 || stall_t !== 1'b0) begin errors++;
      $display("FAIL tmo_err got cyc=%b err=%b rvalid=%b rdata=%h stall=%b want 0 1 1 0 0",
               cyc_t, err_t, rvalid_t, rdata_t, stall_t); end
    next_cycle(); ack_t = 1; wb_data_in = 32'h99; #1;
    checks++; if (err_t !== 1'b0 || rvalid_t !== 1'b0) begin errors++;
      $display("FAIL tmo_pulse got err=%b rvalid=%b want 0 0", err_t, rvalid_t); end
    next_cycle(); ack_t = 0; #1;
    checks++; if (rvalid_t !== 1'b0 || rdata_t !== 32'h0) begin errors++;
      $display("FAIL tmo_late got rvalid=%b rdata=%h want 0 0", rvalid_t, rdata_t); end
  endtask

  task automatic test_classic();
    next_cycle(); req_c = 1; core_addr = 32'h400; #1;
    next_cycle(); req_c = 0; #1;
    checks++; if (stb_c !== 1'b1 || cyc_c !== 1'b1) begin errors++;
      $display("FAIL cl_stb1 got stb=%b cyc=%b want 1 1", stb_c, cyc_c); end
    next_cycle(); #1;
    checks++; if (stb_c !== 1'b1 || rvalid_c !== 1'b0) begin errors++;
      $display("FAIL cl_stb2 got stb=%b rvalid=%b want 1 0", stb_c, rvalid_c); end
    next_cycle(); ack_c = 1; wb_data_in = 32'hA5A5A5A5; #1;
    checks++; if (stb_c !== 1'b1 || rvalid_c !== 1'b1 || rdata_c !== 32'hA5A5A5A5 ||
                  stall_c !== 1'b0) begin errors++;
      $display("FAIL cl_ack got stb=%b rvalid=%b rdata=%h stall=%b want 1 1 a5a5a5a5 0",
               stb_c, rvalid_c, rdata_c, stall_c); end
    next_cycle(); ack_c = 0; wb_data_in = 32'h0; #1;
    checks++; if (stb_c !== 1'b0 || cyc_c !== 1'b0 || rvalid_c !== 1'b0 ||
                  rdata_c !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL cl_after got stb=%b cyc=%b rvalid=%b rdata=%h want 0 0 0 a5a5a5a5",
               stb_c, cyc_c, rvalid_c, rdata_c); end
  endtask

  task automatic test_reset_mid();
    next_cycle(); req_a = 1; core_addr = 32'h500; #1;
    next_cycle(); req_a = 0; #1;
    next_cycle(); #1;
    checks++; if (cyc_a !== 1'b1 || stb_a !== 1'b0) begin errors++;
      $display("FAIL mid_wait got cyc=%b stb=%b want 1 0", cyc_a, stb_a); end
    rst_n = 0; #1;
    checks++; if ({cyc_a, stb_a, stall_a, rvalid_a} !== 4'b0 || rdata_a !== 32'h0) begin
      errors++; $display("FAIL mid_rst got cyc/stb/stall/rvalid=%b rdata=%h want 0000 0",
                         {cyc_a, stb_a, stall_a, rvalid_a}, rdata_a); end
    next_cycle(); ack_a = 1; #1;
    rst_n = 1; req_a = 1; core_addr = 32'h600; #1;
    checks++; if (rvalid_a !== 1'b0) begin errors++;
      $display("FAIL mid_noresp got rvalid=%b want 0", rvalid_a); end
    next_cycle(); req_a = 0; ack_a = 0; #1;
    checks++; if (stb_a !== 1'b1 || addr_a !== 32'h600) begin errors++;
      $display("FAIL mid_accept got stb=%b addr=%h want 1 600", stb_a, addr_a); end
    next_cycle(); ack_a = 1; wb_data_in = 32'h0BADF00D; #1;
    next_cycle(); ack_a = 0; #1;
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'h0BADF00D) begin errors++;
      $display("FAIL mid_done got rvalid=%b rdata=%h want 1 0badf00d", rvalid_a, rdata_a); end
  endtask

  initial begin
    test_reset();
    test_pipe_read();
    test_byte_write();
    test_stall();
    test_ack_in_req();
    test_timeout();
    test_classic();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
